reg_file_wb: RTL and testbench

// - 32x32 integer register file: write-back end of the WB data path. Consumes the

---
 rtl/reg_file_wb_pkg.sv | 18 +
 rtl/reg_file_wb_read_port.sv | 24 ++
 rtl/reg_file_wb.sv | 115 +++++++++++
 tb/tb_reg_file_wb.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/reg_file_wb_pkg.sv
// Shared definitions for the write-back data path: widths, register count,
// the hardwired-zero index and the WB select encodings used by the WB mux.
package reg_file_wb_pkg;

    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int NREG = 2 ** AW;

    localparam logic [AW-1:0] REG_ZERO = 5'd0;

    // Write-back source select; the WB mux and this block share this encoding.
    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_EXT = 2'd1,
        WB_PC  = 2'd2
    } wb_sel_e;

endpackage : reg_file_wb_pkg

// File: rtl/reg_file_wb_read_port.sv
// One combinational read port: x0 reads zero, a matching in-flight write is
// forwarded, otherwise the stored register value is returned.
module rf_read_port
    import reg_file_wb_pkg::*;
(
    input  logic [AW-1:0]   idx,
    input  logic [XLEN-1:0] regs [NREG],
    input  logic            byp_en,
    input  logic [AW-1:0]   byp_idx,
    input  logic [XLEN-1:0] byp_data,
    output logic [XLEN-1:0] data
);

    // Zero register first, then same-cycle forwarding, then storage.
    always_comb begin
        data = regs[idx];
        if (idx == REG_ZERO) begin
            data = '0;
        end else if (byp_en && (byp_idx == idx)) begin
            data = byp_data;
        end
    end

endmodule : rf_read_port

// File: rtl/reg_file_wb.sv
// 32x32 integer register file at the write-back end of the pipeline.
// Two bypassed read ports for ID, one unbypassed debug port, and a registered
// trace of the last committed write plus a running commit counter.
module reg_file_wb
    import reg_file_wb_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            rf_we,
    input  logic [AW-1:0]   wR,
    input  logic [XLEN-1:0] wD,
    input  logic [AW-1:0]   rR1,
    input  logic [AW-1:0]   rR2,
    output logic [XLEN-1:0] rD1,
    output logic [XLEN-1:0] rD2,
    input  logic [AW-1:0]   dbg_sel,
    output logic [XLEN-1:0] dbg_data,
    output logic            trace_valid,
    output logic [AW-1:0]   trace_reg,
    output logic [XLEN-1:0] trace_data,
    output logic [31:0]     wr_count
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic            trace_valid_q, trace_valid_d;
    logic [AW-1:0]   trace_reg_q,   trace_reg_d;
    logic [XLEN-1:0] trace_data_q,  trace_data_d;
    logic [31:0]     wr_count_q,    wr_count_d;

    logic commit;
    logic byp_en;

    // A write commits only to a non-zero destination.
    assign commit = rf_we && (wR != REG_ZERO);
    // Forwarding is suppressed while reset is held so reads stay at zero.
    assign byp_en = commit && !rst;

    // Next-state for storage, trace and counter; hold unless a write commits.
    always_comb begin
        regs_d        = regs_q;
        trace_valid_d = 1'b0;
        trace_reg_d   = trace_reg_q;
        trace_data_d  = trace_data_q;
        wr_count_d    = wr_count_q;
        if (commit) begin
            regs_d[wR]    = wD;
            trace_valid_d = 1'b1;
            trace_reg_d   = wR;
            trace_data_d  = wD;
            wr_count_d    = wr_count_q + 32'd1;
        end
        regs_d[0] = '0;
    end

    // Register array; async reset clears every entry and discards a pending write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Trace port and commit counter; counter wraps naturally at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trace_valid_q <= 1'b0;
            trace_reg_q   <= '0;
            trace_data_q  <= '0;
            wr_count_q    <= '0;
        end else begin
            trace_valid_q <= trace_valid_d;
            trace_reg_q   <= trace_reg_d;
            trace_data_q  <= trace_data_d;
            wr_count_q    <= wr_count_d;
        end
    end

    rf_read_port u_rd1 (
        .idx      (rR1),
        .regs     (regs_q),
        .byp_en   (byp_en),
        .byp_idx  (wR),
        .byp_data (wD),
        .data     (rD1)
    );

    rf_read_port u_rd2 (
        .idx      (rR2),
        .regs     (regs_q),
        .byp_en   (byp_en),
        .byp_idx  (wR),
        .byp_data (wD),
        .data     (rD2)
    );

    // Debug view shows committed state only, so forwarding is tied off.
    rf_read_port u_dbg (
        .idx      (dbg_sel),
        .regs     (regs_q),
        .byp_en   (1'b0),
        .byp_idx  (REG_ZERO),
        .byp_data ('0),
        .data     (dbg_data)
    );

    assign trace_valid = trace_valid_q;
    assign trace_reg   = trace_reg_q;
    assign trace_data  = trace_data_q;
    assign wr_count    = wr_count_q;

endmodule : reg_file_wb

// File: tb/tb_reg_file_wb.sv
// Bench for reg_file_wb: a directed vector table, a mid-run reset sequence,
// then randomized traffic checked against an array-based reference model.
module tb_reg_file_wb;

    logic        clk;
    logic        rst;
    logic        rf_we;
    logic [4:0]  wR;
    logic [31:0] wD;
    logic [4:0]  rR1, rR2, dbg_sel;
    logic [31:0] rD1, rD2, dbg_data;
    logic        trace_valid;
    logic [4:0]  trace_reg;
    logic [31:0] trace_data;
    logic [31:0] wr_count;

    int checks   = 0;
    int failures = 0;

    reg_file_wb dut (
        .clk         (clk),
        .rst         (rst),
        .rf_we       (rf_we),
        .wR          (wR),
        .wD          (wD),
        .rR1         (rR1),
        .rR2         (rR2),
        .rD1         (rD1),
        .rD2         (rD2),
        .dbg_sel     (dbg_sel),
        .dbg_data    (dbg_data),
        .trace_valid (trace_valid),
        .trace_reg   (trace_reg),
        .trace_data  (trace_data),
        .wr_count    (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, exp, $time);
        end
    endtask

    // Directed vector: inputs applied after a falling edge, expected
    // combinational reads before the next rising edge, and expected trace /
    // counter state left by the previous rising edges.
    typedef struct {
        logic        we;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [4:0]  dbg;
        logic [31:0] e1;
        logic [31:0] e2;
        logic [31:0] edbg;
        logic        etv;
        logic [4:0]  ereg;
        logic [31:0] edata;
        logic [31:0] ecnt;
    } vec_t;

    function automatic vec_t mk(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                                input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] dbg,
                                input logic [31:0] e1, input logic [31:0] e2, input logic [31:0] edbg,
                                input logic etv, input logic [4:0] ereg, input logic [31:0] edata,
                                input logic [31:0] ecnt);
        vec_t v;
        v.we = we; v.wr = wr; v.wd = wd; v.r1 = r1; v.r2 = r2; v.dbg = dbg;
        v.e1 = e1; v.e2 = e2; v.edbg = edbg;
        v.etv = etv; v.ereg = ereg; v.edata = edata; v.ecnt = ecnt;
        return v;
    endfunction

    vec_t vecs[10];

    // Reference model state
    logic [31:0] m_regs [32];
    logic        m_tv;
    logic [4:0]  m_treg;
    logic [31:0] m_tdata;
    logic [31:0] m_cnt;

    function automatic logic [31:0] m_read(input logic [4:0] idx, input logic we,
                                           input logic [4:0] wr, input logic [31:0] wd);
        if (idx == 5'd0) return 32'd0;
        if (we && wr == idx) return wd;
        return m_regs[idx];
    endfunction

    initial begin
        //              we  wr     wd            r1     r2     dbg    e1            e2            edbg          tv    reg    data          cnt
        vecs[0] = mk(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 5'd5, 32'hDEADBEEF, 32'h0,        32'h0,        1'b0, 5'd0, 32'h0,        32'd0);
        vecs[1] = mk(1'b0, 5'd0, 32'h0,        5'd5, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 5'd5, 32'hDEADBEEF, 32'd1);
        vecs[2] = mk(1'b1, 5'd0, 32'h12345678, 5'd0, 5'd5, 5'd0, 32'h0,        32'hDEADBEEF, 32'h0,        1'b0, 5'd5, 32'hDEADBEEF, 32'd1);
        vecs[3] = mk(1'b0, 5'd0, 32'h0,        5'd0, 5'd0, 5'd5, 32'h0,        32'h0,        32'hDEADBEEF, 1'b0, 5'd5, 32'hDEADBEEF, 32'd1);
        vecs[4] = mk(1'b1, 5'd7, 32'h1,        5'd7, 5'd5, 5'd7, 32'h1,        32'hDEADBEEF, 32'h0,        1'b0, 5'd5, 32'hDEADBEEF, 32'd1);
        vecs[5] = mk(1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd7, 5'd7, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h1,        1'b1, 5'd7, 32'h1,        32'd2);
        vecs[6] = mk(1'b1, 5'd3, 32'h11,       5'd7, 5'd3, 5'd7, 32'hA5A5A5A5, 32'h11,       32'hA5A5A5A5, 1'b1, 5'd7, 32'hA5A5A5A5, 32'd3);
        vecs[7] = mk(1'b1, 5'd3, 32'h22,       5'd3, 5'd3, 5'd3, 32'h22,       32'h22,       32'h11,       1'b1, 5'd3, 32'h11,       32'd4);
        vecs[8] = mk(1'b0, 5'd3, 32'h99,       5'd3, 5'd7, 5'd3, 32'h22,       32'hA5A5A5A5, 32'h22,       1'b1, 5'd3, 32'h22,       32'd5);
        vecs[9] = mk(1'b0, 5'd0, 32'h0,        5'd3, 5'd5, 5'd0, 32'h22,       32'hDEADBEEF, 32'h0,        1'b0, 5'd3, 32'h22,       32'd5);

        rst = 1'b1; rf_we = 1'b0; wR = '0; wD = '0; rR1 = '0; rR2 = '0; dbg_sel = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed table
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rf_we = vecs[i].we; wR = vecs[i].wr; wD = vecs[i].wd;
            rR1 = vecs[i].r1; rR2 = vecs[i].r2; dbg_sel = vecs[i].dbg;
            #1;
            $display("vec %0d we=%0b wR=%0d wD=%08h rR1=%0d rD1=%08h rR2=%0d rD2=%08h dbg=%08h tv=%0b cnt=%0d",
                     i, rf_we, wR, wD, rR1, rD1, rR2, rD2, dbg_data, trace_valid, wr_count);
            chk($sformatf("vec%0d_rD1", i), rD1, vecs[i].e1);
            chk($sformatf("vec%0d_rD2", i), rD2, vecs[i].e2);
            chk($sformatf("vec%0d_dbg", i), dbg_data, vecs[i].edbg);
            chk($sformatf("vec%0d_tvalid", i), {31'd0, trace_valid}, {31'd0, vecs[i].etv});
            chk($sformatf("vec%0d_treg", i), {27'd0, trace_reg}, {27'd0, vecs[i].ereg});
            chk($sformatf("vec%0d_tdata", i), trace_data, vecs[i].edata);
            chk($sformatf("vec%0d_cnt", i), wr_count, vecs[i].ecnt);
        end

        // Mid-run reset with a write pending: everything reads zero, write discarded.
        @(negedge clk);
        rf_we = 1'b1; wR = 5'd9; wD = 32'hCAFEF00D;
        rR1 = 5'd3; rR2 = 5'd9; dbg_sel = 5'd7;
        #1 rst = 1'b1;
        #1;
        $display("reset-async rD1=%08h rD2=%08h dbg=%08h tv=%0b cnt=%0d", rD1, rD2, dbg_data, trace_valid, wr_count);
        chk("rst_async_rD1", rD1, 32'h0);
        chk("rst_async_rD2", rD2, 32'h0);
        chk("rst_async_dbg", dbg_data, 32'h0);
        chk("rst_async_cnt", wr_count, 32'h0);
        @(posedge clk); #1;
        $display("reset-edge rD1=%08h rD2=%08h tv=%0b treg=%0d tdata=%08h cnt=%0d", rD1, rD2, trace_valid, trace_reg, trace_data, wr_count);
        chk("rst_edge_rD2", rD2, 32'h0);
        chk("rst_edge_tvalid", {31'd0, trace_valid}, 32'h0);
        chk("rst_edge_tdata", trace_data, 32'h0);
        chk("rst_edge_cnt", wr_count, 32'h0);
        @(negedge clk);
        rf_we = 1'b0; dbg_sel = 5'd9;
        rst = 1'b0;
        #1;
        chk("post_rst_dbg9", dbg_data, 32'h0);

        // Randomized traffic against the reference model
        for (int r = 0; r < 32; r++) m_regs[r] = '0;
        m_tv = 1'b0; m_treg = '0; m_tdata = '0; m_cnt = '0;

        for (int c = 0; c < 10000; c++) begin
            logic [31:0] e1, e2, ed;
            logic        commit;
            @(negedge clk);
            rf_we = ($urandom_range(0, 3) != 0);
            wR    = 5'($urandom_range(0, 31));
            wD    = $urandom;
            rR1   = ($urandom_range(0, 2) == 0) ? wR : 5'($urandom_range(0, 31));
            rR2   = ($urandom_range(0, 2) == 0) ? wR : 5'($urandom_range(0, 31));
            dbg_sel = 5'($urandom_range(0, 31));
            #1;
            e1 = m_read(rR1, rf_we, wR, wD);
            e2 = m_read(rR2, rf_we, wR, wD);
            ed = (dbg_sel == 5'd0) ? 32'd0 : m_regs[dbg_sel];
            if (c < 8)
                $display("rand %0d we=%0b wR=%0d wD=%08h rD1=%08h rD2=%08h dbg=%08h", c, rf_we, wR, wD, rD1, rD2, dbg_data);
            chk("rand_rD1", rD1, e1);
            chk("rand_rD2", rD2, e2);
            chk("rand_dbg_pre", dbg_data, ed);
            @(posedge clk);
            commit = rf_we && (wR != 5'd0);
            if (commit) begin
                m_regs[wR] = wD;
                m_cnt = m_cnt + 32'd1;
                m_treg = wR;
                m_tdata = wD;
            end
            m_tv = commit;
            #1;
            chk("rand_tvalid", {31'd0, trace_valid}, {31'd0, m_tv});
            chk("rand_treg", {27'd0, trace_reg}, {27'd0, m_treg});
            chk("rand_tdata", trace_data, m_tdata);
            chk("rand_cnt", wr_count, m_cnt);
            chk("rand_dbg_post", dbg_data, (dbg_sel == 5'd0) ? 32'd0 : m_regs[dbg_sel]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_reg_file_wb
